spi_master: RTL and testbench

- SPI mode-0 master that drives the CS/SCLK/MOSI side of the link and captures MISO.
- Bridges a system-clock parallel request interface to the SPI slave block: one WIDTH-bit word per transfer, MSB first.
- The whole block runs on the system clock; SCLK is a registered divided output, not a clock domain.

---
 rtl/spi_master.sv | 193 +++++++++++++++++++
 tb/tb_spi_master.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master, one WIDTH-bit word per transfer, MSB first, SCLK divided from clk.
// Optional macro SPI_MASTER_BURST_EN adds a WAIT state that keeps CS low between chained words.
module spi_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             burst,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             cs_n,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS     = BW'(WIDTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_SHIFT_HI = 3'd2;
  localparam logic [2:0] S_SHIFT_LO = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;
`ifdef SPI_MASTER_BURST_EN
  localparam logic [2:0] S_WAIT     = 3'd6;
`endif

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             accept;

`ifdef SPI_MASTER_BURST_EN
  logic burst_q, burst_d;
  assign accept = start && (state_q == S_IDLE || state_q == S_WAIT);
`else
  logic unused_burst;
  assign unused_burst = burst;
  assign accept = start && (state_q == S_IDLE);
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    div_d   = div_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
`ifdef SPI_MASTER_BURST_EN
    burst_d = burst_q;
`endif
    if (accept) begin
      sr_d    = tx_data;
      cs_n_d  = 1'b0;
      mosi_d  = tx_data[WIDTH-1];
      busy_d  = 1'b1;
      div_d   = DIV_LAST;
      bit_d   = '0;
      state_d = S_SETUP;
`ifdef SPI_MASTER_BURST_EN
      burst_d = burst;
`endif
    end else begin
      case (state_q)
        // Rising edges sample miso into the LSB; the shifted MSB is the next bit out.
        S_SETUP, S_SHIFT_LO: begin
          if (div_q == '0) begin
            sclk_d  = 1'b1;
            sr_d    = {sr_q[WIDTH-2:0], miso};
            bit_d   = bit_q + BW'(1);
            div_d   = DIV_LAST;
            state_d = S_SHIFT_HI;
          end else begin
            div_d = div_q - DW'(1);
          end
        end
        S_SHIFT_HI: begin
          if (div_q == '0) begin
            sclk_d = 1'b0;
            div_d  = DIV_LAST;
            if (bit_q == BITS) begin
              state_d = S_HOLD;
            end else begin
              mosi_d  = sr_q[WIDTH-1];
              state_d = S_SHIFT_LO;
            end
          end else begin
            div_d = div_q - DW'(1);
          end
        end
        S_HOLD: begin
          if (div_q == '0) begin
            rx_d   = sr_q;
            done_d = 1'b1;
            div_d  = DIV_LAST;
`ifdef SPI_MASTER_BURST_EN
            if (burst_q) begin
              busy_d  = 1'b0;
              state_d = S_WAIT;
            end else
`endif
            begin
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              state_d = S_GAP;
            end
          end else begin
            div_d = div_q - DW'(1);
          end
        end
        S_GAP: begin
          if (div_q == '0) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            div_d = div_q - DW'(1);
          end
        end
`ifdef SPI_MASTER_BURST_EN
        S_WAIT: begin
          if (!burst) begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            busy_d  = 1'b1;
            div_d   = DIV_LAST;
            state_d = S_GAP;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      rx_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
      burst_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
`ifdef SPI_MASTER_BURST_EN
      burst_q <= burst_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_q;
  assign cs_n    = cs_n_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: an 8-bit/CLK_DIV=2 instance and a 16-bit/CLK_DIV=1 instance.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, burst8, busy8, done8, cs8, sclk8, mosi8, miso8;
  logic [7:0] tx8, rx8;
  logic        start16, busy16, done16, cs16, sclk16, mosi16;
  logic [15:0] tx16, rx16;
  logic       loop8;
  logic [7:0] slv;

  int vectors = 0;
  int fails   = 0;

  assign miso8 = loop8 ? mosi8 : slv[7];

  spi_master #(.WIDTH(8), .CLK_DIV(2)) u8 (
    .clk(clk), .rst(rst), .start(start8), .tx_data(tx8), .burst(burst8),
    .busy(busy8), .done(done8), .rx_data(rx8), .cs_n(cs8), .sclk(sclk8),
    .mosi(mosi8), .miso(miso8)
  );

  spi_master #(.WIDTH(16), .CLK_DIV(1)) u16 (
    .clk(clk), .rst(rst), .start(start16), .tx_data(tx16), .burst(1'b0),
    .busy(busy16), .done(done16), .rx_data(rx16), .cs_n(cs16), .sclk(sclk16),
    .mosi(mosi16), .miso(mosi16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8-bit transfer; inj = cycle after accept to pulse a stray start, rstc = cycle to hit reset.
  task automatic run8(input string tg, input logic [7:0] tx, input logic lp, input logic [7:0] sw,
                      input int inj, input int rstc, input logic [7:0] exp_rx, input logic [7:0] exp_bits);
    int edges = 0, dones = 0, done_at = 0, idle_at = 0;
    logic [7:0] bits = 8'h00;
    logic prev = 1'b0;
    @(negedge clk);
    loop8 = lp; slv = sw; tx8 = tx; start8 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start8 = (n == inj);
      if (n == inj) tx8 = 8'hFF;
      if (sclk8 && !prev) begin edges++; bits = {bits[6:0], mosi8}; end
      if (!sclk8 && prev) slv = {slv[6:0], 1'b0};
      prev = sclk8;
      if (done8) begin dones++; done_at = n; end
      if (!busy8 && idle_at == 0) idle_at = n;
      if (n == rstc) begin
        rst = 1'b1;
        #1;
        check({tg, "_rst_cs_n"}, 32'(cs8), 32'd1);
        check({tg, "_rst_sclk"}, 32'(sclk8), 32'd0);
        check({tg, "_rst_busy"}, 32'(busy8), 32'd0);
        check({tg, "_rst_done"}, 32'(done8), 32'd0);
        check({tg, "_rst_rx"}, 32'(rx8), 32'd0);
        check({tg, "_rst_no_done_before"}, 32'(dones), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    check({tg, "_rx"}, 32'(rx8), 32'(exp_rx));
    check({tg, "_mosi_bits"}, 32'(bits), 32'(exp_bits));
    check({tg, "_edges"}, 32'(edges), 32'd8);
    check({tg, "_done_cnt"}, 32'(dones), 32'd1);
    check({tg, "_done_at"}, 32'(done_at), 32'd35);
    check({tg, "_idle_at"}, 32'(idle_at), 32'd37);
  endtask

`ifdef SPI_MASTER_BURST_EN
  int b_dn, b_cs_rise, b_first_done;
  logic [7:0] b_r1, b_r2;
`endif
  int e16, d16, run16, max16;

  initial begin
    rst = 1'b1; start8 = 1'b0; burst8 = 1'b0; tx8 = 8'h00; loop8 = 1'b1; slv = 8'h00;
    start16 = 1'b0; tx16 = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_cs_n", 32'(cs8), 32'd1);
    check("reset_sclk", 32'(sclk8), 32'd0);
    check("reset_mosi", 32'(mosi8), 32'd0);
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_rx", 32'(rx8), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run8("loop_a5", 8'hA5, 1'b1, 8'h00, 0, 0, 8'hA5, 8'hA5);
    run8("slave_3c", 8'hC3, 1'b0, 8'h3C, 0, 0, 8'h3C, 8'hC3);
    run8("ignore_start", 8'hA5, 1'b1, 8'h00, 10, 0, 8'hA5, 8'hA5);
    repeat (3) @(negedge clk);
    run8("mid_reset", 8'hA5, 1'b1, 8'h00, 0, 12, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    run8("after_reset", 8'h5A, 1'b1, 8'h00, 0, 0, 8'h5A, 8'h5A);

    // 16-bit word at CLK_DIV=1: done at T+34, every sclk high phase one cycle long.
    e16 = 0; d16 = 0; run16 = 0; max16 = 0;
    @(negedge clk);
    tx16 = 16'h8001; start16 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start16 = 1'b0;
      if (sclk16) begin
        if (run16 == 0) e16++;
        run16++;
        if (run16 > max16) max16 = run16;
      end else begin
        run16 = 0;
      end
      if (done16) d16 = n;
    end
    check("w16_rx", 32'(rx16), 32'h8001);
    check("w16_done_at", 32'(d16), 32'd34);
    check("w16_edges", 32'(e16), 32'd16);
    check("w16_high_len", 32'(max16), 32'd1);
    check("w16_idle", 32'(busy16), 32'd0);

`ifdef SPI_MASTER_BURST_EN
    b_dn = 0; b_cs_rise = 0; b_first_done = 0; b_r1 = 8'h00; b_r2 = 8'h00;
    @(negedge clk);
    loop8 = 1'b1; tx8 = 8'h12; burst8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (n == 36) begin start8 = 1'b1; tx8 = 8'h34; burst8 = 1'b0; end
      if (done8) begin
        b_dn++;
        if (b_dn == 1) begin b_r1 = rx8; b_first_done = n; end
        else b_r2 = rx8;
      end
      if (cs8 && b_cs_rise == 0) b_cs_rise = n;
    end
    check("burst_done_cnt", 32'(b_dn), 32'd2);
    check("burst_first_done_at", 32'(b_first_done), 32'd35);
    check("burst_rx1", 32'(b_r1), 32'h12);
    check("burst_rx2", 32'(b_r2), 32'h34);
    check("burst_cs_rise_at", 32'(b_cs_rise), 32'd71);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
